// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control sequencer for the ALU execute stage.
// Accepts one decoded op at a time, walks it through LOAD, EXEC and CAPTURE,
// drives the ALU register strobes and op enables, and then hands the result to
// writeback. Compare ops write the flags in CAPTURE and skip writeback.
//
// Optional build macro EXEC_PERF_CNT_EN: when defined, perf_retired counts
// retired ops (WB handshakes plus cmp captures) and wraps at 32 bits. When it
// is undefined, perf_retired is tied to zero and no counter is built.
//
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high. issue_ready is high only in IDLE. wb_valid and wb_rd are held stable
// until the edge where wb_ready is seen. Neither side depends on the other
// asserting first.
module exec_sequencer #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4,
    parameter int RD_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [3:0]      issue_op,
    input  logic            issue_imm,
    input  logic [RD_W-1:0] issue_rd,
    output logic            ldA,
    output logic            ldB,
    output logic            ldResult,
    output logic            clrA,
    output logic            clrB,
    output logic            clrResult,
    output logic [2:0]      aluSel,
    output logic            isImmediate,
    output logic            isAdd,
    output logic            isSub,
    output logic            isCmp,
    output logic            isMul,
    output logic            isDiv,
    output logic            isMod,
    output logic            isLsl,
    output logic            isLsr,
    output logic            isAsr,
    output logic            isOr,
    output logic            isNot,
    output logic            isAnd,
    output logic            isMov,
    output logic            wrFlag,
    output logic            illegal_op,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     perf_retired,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_EXEC    = 3'd2,
        S_CAPTURE = 3'd3,
        S_WB      = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_LSL = 4'd10;
    localparam logic [3:0] OP_LSR = 4'd11;
    localparam logic [3:0] OP_ASR = 4'd12;

    localparam logic [2:0] SEL_ADDER = 3'd0;
    localparam logic [2:0] SEL_MUL   = 3'd1;
    localparam logic [2:0] SEL_DIV   = 3'd2;
    localparam logic [2:0] SEL_MOV   = 3'd3;
    localparam logic [2:0] SEL_LOGIC = 3'd4;
    localparam logic [2:0] SEL_SHIFT = 3'd5;

    // The EXEC counter is loaded with latency-1 and the state leaves on zero,
    // so EXEC lasts exactly the latency in cycles.
    localparam logic [3:0] MUL_LAT_M1 = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_LAT_M1 = 4'(DIV_LAT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      op_q;
    logic            imm_q;
    logic [RD_W-1:0] rd_q;
    logic [3:0]      cnt_q;

    logic            op_legal;
    logic            op_is_cmp;
    logic [2:0]      dec_sel;
    logic [3:0]      dec_lat_m1;
    logic            hold;

    assign clrA      = rst;
    assign clrB      = rst;
    assign clrResult = rst;
    assign dbg_state = state;

    // Decode the latched opcode into unit select, EXEC latency and legality.
    always_comb begin
        op_legal   = (op_q <= OP_ASR);
        op_is_cmp  = (op_q == OP_CMP);
        dec_sel    = SEL_ADDER;
        dec_lat_m1 = 4'd0;
        case (op_q)
            OP_ADD, OP_SUB, OP_CMP: dec_sel = SEL_ADDER;
            OP_MUL: begin
                dec_sel    = SEL_MUL;
                dec_lat_m1 = MUL_LAT_M1;
            end
            OP_DIV, OP_MOD: begin
                dec_sel    = SEL_DIV;
                dec_lat_m1 = DIV_LAT_M1;
            end
            OP_MOV:                 dec_sel = SEL_MOV;
            OP_OR, OP_AND, OP_NOT:  dec_sel = SEL_LOGIC;
            OP_LSL, OP_LSR, OP_ASR: dec_sel = SEL_SHIFT;
            default:                dec_sel = SEL_ADDER;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the accepted op and run the EXEC latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= 4'd0;
            imm_q <= 1'b0;
            rd_q  <= '0;
            cnt_q <= 4'd0;
        end else begin
            if (state == S_IDLE && issue_valid) begin
                op_q  <= issue_op;
                imm_q <= issue_imm;
                rd_q  <= issue_rd;
            end
            if (state == S_LOAD) begin
                cnt_q <= dec_lat_m1;
            end else if (state == S_EXEC && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Next-state logic and all control outputs; reset forces the idle values.
    always_comb begin
        state_nxt   = state;
        issue_ready = 1'b0;
        ldA         = 1'b0;
        ldB         = 1'b0;
        ldResult    = 1'b0;
        wrFlag      = 1'b0;
        illegal_op  = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        hold        = 1'b0;
        aluSel      = 3'd0;
        isImmediate = 1'b0;
        isAdd       = 1'b0;
        isSub       = 1'b0;
        isCmp       = 1'b0;
        isMul       = 1'b0;
        isDiv       = 1'b0;
        isMod       = 1'b0;
        isLsl       = 1'b0;
        isLsr       = 1'b0;
        isAsr       = 1'b0;
        isOr        = 1'b0;
        isNot       = 1'b0;
        isAnd       = 1'b0;
        isMov       = 1'b0;

        case (state)
            S_IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (op_legal) begin
                    ldA       = 1'b1;
                    ldB       = 1'b1;
                    hold      = 1'b1;
                    state_nxt = S_EXEC;
                end else begin
                    illegal_op = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            S_EXEC: begin
                hold = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                hold = 1'b1;
                if (op_is_cmp) begin
                    wrFlag    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    ldResult  = 1'b1;
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                wb_valid = 1'b1;
                wb_rd    = rd_q;
                if (wb_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Enables stay constant from LOAD through CAPTURE for a legal op.
        if (hold) begin
            aluSel      = dec_sel;
            isImmediate = imm_q;
            isAdd       = (op_q == OP_ADD);
            isSub       = (op_q == OP_SUB);
            isMul       = (op_q == OP_MUL);
            isDiv       = (op_q == OP_DIV);
            isMod       = (op_q == OP_MOD);
            isCmp       = (op_q == OP_CMP);
            isMov       = (op_q == OP_MOV);
            isOr        = (op_q == OP_OR);
            isAnd       = (op_q == OP_AND);
            isNot       = (op_q == OP_NOT);
            isLsl       = (op_q == OP_LSL);
            isLsr       = (op_q == OP_LSR);
            isAsr       = (op_q == OP_ASR);
        end

        // Reset aborts any op in flight: no strobes, no writeback, no flags.
        if (rst) begin
            state_nxt   = S_IDLE;
            issue_ready = 1'b1;
            ldA         = 1'b0;
            ldB         = 1'b0;
            ldResult    = 1'b0;
            wrFlag      = 1'b0;
            illegal_op  = 1'b0;
            wb_valid    = 1'b0;
            wb_rd       = '0;
            aluSel      = 3'd0;
            isImmediate = 1'b0;
            isAdd       = 1'b0;
            isSub       = 1'b0;
            isCmp       = 1'b0;
            isMul       = 1'b0;
            isDiv       = 1'b0;
            isMod       = 1'b0;
            isLsl       = 1'b0;
            isLsr       = 1'b0;
            isAsr       = 1'b0;
            isOr        = 1'b0;
            isNot       = 1'b0;
            isAnd       = 1'b0;
            isMov       = 1'b0;
        end
    end

`ifdef EXEC_PERF_CNT_EN
    logic [31:0] perf_q;

    // Count retirements: writeback handshakes and compare captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= 32'd0;
        end else if ((state == S_WB && wb_ready) || (state == S_CAPTURE && op_is_cmp)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_retired = perf_q;
`else
    assign perf_retired = 32'd0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: randomized and directed bench for exec_sequencer with an
// event scoreboard (illegal pulse, flag write, writeback presentation).
module tb_exec_sequencer;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;
    localparam int RD_W    = 4;
    localparam int EW      = 2 + RD_W + 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            issue_valid;
    logic            issue_ready;
    logic [3:0]      issue_op;
    logic            issue_imm;
    logic [RD_W-1:0] issue_rd;
    logic ldA, ldB, ldResult, clrA, clrB, clrResult;
    logic [2:0] aluSel;
    logic isImmediate, isAdd, isSub, isCmp, isMul, isDiv, isMod;
    logic isLsl, isLsr, isAsr, isOr, isNot, isAnd, isMov;
    logic wrFlag, illegal_op, wb_valid, wb_ready;
    logic [RD_W-1:0] wb_rd;
    logic [31:0] perf_retired;
    logic [2:0]  dbg_state;

    exec_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_imm(issue_imm), .issue_rd(issue_rd),
        .ldA(ldA), .ldB(ldB), .ldResult(ldResult),
        .clrA(clrA), .clrB(clrB), .clrResult(clrResult),
        .aluSel(aluSel), .isImmediate(isImmediate),
        .isAdd(isAdd), .isSub(isSub), .isCmp(isCmp), .isMul(isMul), .isDiv(isDiv),
        .isMod(isMod), .isLsl(isLsl), .isLsr(isLsr), .isAsr(isAsr), .isOr(isOr),
        .isNot(isNot), .isAnd(isAnd), .isMov(isMov),
        .wrFlag(wrFlag), .illegal_op(illegal_op),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .perf_retired(perf_retired), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int model_retired = 0;
    logic [EW-1:0] exp_q[$];
    logic rand_ready  = 1'b0;
    logic force_ready = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Reference: opcode -> unit select and EXEC latency, straight from the op table.
    function automatic logic [2:0] sel_of(input logic [3:0] op);
        case (op)
            4'd2:                return 3'd1;
            4'd3, 4'd4:          return 3'd2;
            4'd6:                return 3'd3;
            4'd7, 4'd8, 4'd9:    return 3'd4;
            4'd10, 4'd11, 4'd12: return 3'd5;
            default:             return 3'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        if (op == 4'd2) return MUL_LAT;
        if (op == 4'd3 || op == 4'd4) return DIV_LAT;
        return 1;
    endfunction

    // Observed control vector; enable bit n corresponds to opcode n.
    function automatic logic [21:0] strobes();
        return {ldA, ldB, ldResult, wrFlag, illegal_op, isImmediate, aluSel,
                isAsr, isLsr, isLsl, isNot, isAnd, isOr, isMov,
                isCmp, isMod, isDiv, isMul, isSub, isAdd};
    endfunction

    function automatic logic [21:0] exp_vec(input logic [3:0] op, input logic imm, input logic ld,
                                            input logic ldr, input logic wf, input logic ill,
                                            input logic hold);
        logic [12:0] en;
        en = hold ? (13'd1 << op) : 13'd0;
        return {ld, ld, ldr, wf, ill, hold & imm, (hold ? sel_of(op) : 3'd0), en};
    endfunction

    // ---------------- writeback ready driver ----------------
    initial begin
        wb_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            wb_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one op and checks the per-cycle control vector up to CAPTURE.
    // Pushes the expected observable event with the cycle it should appear.
    task automatic issue(input logic [3:0] op, input logic imm, input logic [RD_W-1:0] rd,
                         input int abort_at, output int e0);
        int lat, last, n;
        logic legal, cmp;
        legal = (op < 4'd13);
        cmp   = (op == 4'd5);
        lat   = lat_of(op);
        last  = legal ? 1 + lat : 0;
        e0    = -1;
        n     = 0;
        while (!issue_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!issue_ready) begin
            chk("issue_ready_timeout", 32'(issue_ready), 32'd1);
            return;
        end
        issue_valid = 1'b1;
        issue_op    = op;
        issue_imm   = imm;
        issue_rd    = rd;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        issue_op    = 4'($urandom_range(0, 15));
        issue_rd    = RD_W'($urandom_range(0, 15));
        e0 = cyc;
        if (!legal)   exp_q.push_back({2'd1, {RD_W{1'b0}}, 16'(e0)});
        else if (cmp) exp_q.push_back({2'd2, {RD_W{1'b0}}, 16'(e0 + 1 + lat)});
        else          exp_q.push_back({2'd3, rd, 16'(e0 + 2 + lat)});
        if (legal) model_retired++;
        for (int k = 0; k <= last; k++) begin
            if (k == abort_at) return;
            if (legal)
                chk("strobes", 32'(strobes()),
                    32'(exp_vec(op, imm, k == 0, (k == last) && !cmp, (k == last) && cmp, 1'b0, 1'b1)));
            else
                chk("strobes_illegal", 32'(strobes()), 32'(exp_vec(op, imm, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
            @(posedge clk);
            #1;
        end
        chk("strobes_after", 32'(strobes()), 32'd0);
        if (!legal || cmp) chk("ready_back", 32'(issue_ready), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wb_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size() != 0 || wb_valid), 32'd0);
    endtask

    task automatic check_perf();
`ifdef EXEC_PERF_CNT_EN
        chk("perf", perf_retired, 32'(model_retired));
`else
        chk("perf", perf_retired, 32'd0);
`endif
    endtask

    // ---------------- monitor ----------------
    logic            mon_pv = 1'b0;
    logic            mon_pr = 1'b0;
    logic [RD_W-1:0] mon_prd = '0;

    initial begin
        logic [1:0]    kind;
        logic [EW-1:0] got;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_pv = 1'b0;
                mon_pr = 1'b0;
            end else begin
                if (mon_pv && !mon_pr) begin
                    chk("wb_hold_valid", 32'(wb_valid), 32'd1);
                    chk("wb_hold_rd", 32'(wb_rd), 32'(mon_prd));
                end
                if (mon_pv && mon_pr) chk("wb_drop", 32'(wb_valid), 32'd0);
                kind = 2'd0;
                if (illegal_op)              kind = 2'd1;
                else if (wrFlag)             kind = 2'd2;
                else if (wb_valid && !mon_pv) kind = 2'd3;
                if (kind != 2'd0) begin
                    got = {kind, (kind == 2'd3) ? wb_rd : {RD_W{1'b0}}, cyc[15:0]};
                    if (exp_q.size() == 0) chk("unexpected_event", 32'(got), 32'd0);
                    else chk("event", 32'(got), 32'(exp_q.pop_front()));
                end
                mon_pv  = wb_valid;
                mon_pr  = wb_ready;
                mon_prd = wb_rd;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        bad++;
        total++;
        $display("FAIL watchdog: got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int e0, e1;
        logic [3:0]      r_op;
        logic            r_imm;
        logic [RD_W-1:0] r_rd;
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_op = 4'd0;
        issue_imm = 1'b0;
        issue_rd = '0;

        @(posedge clk);
        #1;
        chk("rst_clr", 32'({clrA, clrB, clrResult}), 32'd7);
        chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_wb", 32'({wb_valid, wb_rd}), 32'd0);
        chk("rst_perf", perf_retired, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("clr_released", 32'({clrA, clrB, clrResult}), 32'd0);
        chk("idle_ready", 32'(issue_ready), 32'd1);

        // add, writeback always ready
        force_ready = 1'b1;
        issue(4'd0, 1'b0, 4'd3, -1, e0);
        drain();
        check_perf();

        // div with a 5-cycle writeback stall
        force_ready = 1'b0;
        issue(4'd3, 1'b1, 4'd9, -1, e0);
        chk("div_wb_up", 32'(wb_valid), 32'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("div_wb_stalled", 32'({wb_valid, wb_rd}), 32'({1'b1, 4'd9}));
        force_ready = 1'b1;
        drain();
        check_perf();

        // compare: flag write only
        issue(4'd5, 1'b0, 4'd7, -1, e0);
        drain();
        check_perf();

        // illegal opcode, then an add accepted two edges later
        issue(4'd14, 1'b1, 4'd2, -1, e0);
        issue(4'd0, 1'b1, 4'd4, -1, e1);
        chk("illegal_next_accept", 32'(e1 - e0), 32'd2);
        drain();
        check_perf();

        // reset during mul EXEC aborts the op
        issue(4'd2, 1'b0, 4'd5, 2, e0);
        rst = 1'b1;
        exp_q.delete();
        model_retired = 0;
        @(posedge clk);
        #1;
        chk("abort_wb", 32'(wb_valid), 32'd0);
        chk("abort_strobes", 32'(strobes()), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_idle", 32'({issue_ready, wb_valid, wrFlag}), 32'd4);
        check_perf();
        issue(4'd0, 1'b0, 4'd1, -1, e0);
        drain();
        check_perf();

        // randomized ops with random writeback backpressure
        rand_ready = 1'b1;
        repeat (40) begin
            r_op  = 4'($urandom_range(0, 15));
            r_imm = 1'($urandom_range(0, 1));
            r_rd  = RD_W'($urandom_range(0, 15));
            issue(r_op, r_imm, r_rd, -1, e0);
        end
        rand_ready  = 1'b0;
        force_ready = 1'b1;
        drain();
        check_perf();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
